z80_sram_responder: RTL

- Z80 bus responder: the memory/IO target that answers cycles issued by the T80a CPU wrapper.
- Converts CPU memory cycles into timed accesses to an asynchronous external SRAM. Inserts WAIT states and drives the CPU read-data bus.
- Answers IO reads with a floating-bus value and interrupt-acknowledge cycles with a fixed vector.
- Sits between the CPU wrapper and the board SRAM pins, on the CPU clock.

---
 rtl/z80_sram_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/z80_sram_responder.sv
// Z80 bus target: turns CPU memory cycles into timed asynchronous-SRAM accesses with WAIT insertion,
// and answers IO reads with a floating-bus byte and interrupt acknowledge with a fixed vector.
module z80_sram_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ROM_TOP     = 16'h4000,
    parameter logic [7:0]  IM2_VECTOR  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic [15:0] sram_a,
    output logic [7:0]  sram_dq_o,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       wait_q;
    logic       is_read;
    logic [7:0] rd_latch;
    logic       start;
    logic       in_rom;

    assign start  = (state == IDLE) & ~reset & ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
    assign in_rom = (a < ROM_TOP);

    // The start cycle has no registered stall yet, so WAIT is pulled low combinationally.
    assign wait_n = wait_q & ~start;

    always_comb begin
        cpu_di = rd_latch;
        if (!iorq_n && !m1_n)
            cpu_di = IM2_VECTOR;
        else if (!iorq_n && !rd_n)
            cpu_di = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wait_q    <= 1'b1;
            is_read   <= 1'b0;
            rd_latch  <= 8'hFF;
            sram_a    <= 16'h0000;
            sram_dq_o <= 8'h00;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACC;
                        cnt       <= WAIT_INIT;
                        wait_q    <= 1'b0;
                        is_read   <= ~rd_n;
                        sram_a    <= a;
                        sram_dq_o <= cpu_dout;
                        // A protected write runs the full timing with every strobe held inactive.
                        sram_ce_n <= rd_n & in_rom;
                        sram_oe_n <= rd_n;
                        sram_we_n <= ~rd_n | in_rom;
                    end
                end
                ACC: begin
                    if (mreq_n) begin
                        state     <= IDLE;
                        cnt       <= 4'd0;
                        wait_q    <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        if (is_read)
                            rd_latch <= sram_dq_i;
                        state     <= DONE;
                        cnt       <= 4'd0;
                        wait_q    <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Hold here until the CPU ends the cycle so it is never serviced twice.
                    if (mreq_n)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
